// File: rtl/contador_pkg.sv
// contador_pkg -- shared types and helpers for the up/down counter slice.
//   deb_state_t : key debouncer states
//   SEG_HEX     : active-low 7-segment patterns {g,f,e,d,c,b,a} for hex 0-F
//   hex_to_seg  : nibble -> 7-segment pattern lookup
package contador_pkg;

  typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} deb_state_t;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce -- raw active-low key to single-cycle press pulse.
//   clk    in   system clock
//   reset  in   asynchronous active-high reset (FSM -> IDLE)
//   key_n  in   raw key, active-low, asynchronous to clk
//   press  out  1-cycle pulse when a press has been stable DEB_CYCLES cycles
// Optional build macro AUTO_REPEAT_EN: when defined and REPEAT_EN=1, a held
// key re-emits press every RPT_CYCLES cycles after the initial pulse.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 500_000,
  parameter int unsigned RPT_CYCLES = 25_000_000,
  parameter bit          REPEAT_EN  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  import contador_pkg::*;

  localparam int unsigned CW = $clog2(DEB_CYCLES);

  logic [1:0]    sync;
  logic          lvl;
  logic [CW-1:0] cnt;
  logic          deb_done;
  deb_state_t    state, next_state;

  // Two-flop synchroniser; stored inverted so lvl=1 means "pressed".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], ~key_n};
  end

  assign lvl      = sync[1];
  assign deb_done = (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (lvl) next_state = ARM;
      ARM:     if (!lvl) next_state = IDLE;
               else if (deb_done) next_state = HELD;
      HELD:    if (!lvl) next_state = DISARM;
      DISARM:  if (lvl) next_state = HELD;
               else if (deb_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cnt holds how many consecutive qualifying samples preceded this cycle;
  // the sample that triggered the state change counts as the first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 cnt <= '0;
    else if (next_state != state)              cnt <= CW'(1);
    else if (state == ARM || state == DISARM)  cnt <= cnt + CW'(1);
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(RPT_CYCLES + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_hit;

  assign rpt_hit = REPEAT_EN && (state == HELD) && lvl && (rpt_cnt == RW'(RPT_CYCLES));

  // rpt_cnt = cycles since the last emitted pulse (or since re-entering HELD).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            rpt_cnt <= '0;
    else if (next_state != HELD)          rpt_cnt <= '0;
    else if (state != HELD || rpt_hit)    rpt_cnt <= RW'(1);
    else                                  rpt_cnt <= rpt_cnt + RW'(1);
  end
`else
  // Repeat settings have no effect without auto-repeat.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{RPT_CYCLES[0], REPEAT_EN};
`endif

  always_comb begin
    press = (state == ARM) && lvl && deb_done;
`ifdef AUTO_REPEAT_EN
    if (rpt_hit) press = 1'b1;
`endif
  end

endmodule

// File: rtl/contador_ud_fpga.sv
// contador_ud_fpga -- debounced up/down counter with load, terminal flags
// and multi-digit hex 7-segment output.
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   dec_n       in   raw decrement key (active-low)
//   inc_n       in   raw increment key (active-low)
//   load_n      in   raw load key (active-low)
//   init_value  in   N   value loaded on an accepted load press
//   count       out  N   counter value
//   zero        out  count == 0
//   max         out  count == 2^N-1
//   segments    out  7*DIGITS active-low segments, digit 0 in [6:0]
// Optional build macro AUTO_REPEAT_EN: inc/dec keys auto-repeat while held.
module contador_ud_fpga #(
  parameter  int unsigned N          = 6,
  parameter  int unsigned DEB_CYCLES = 500_000,
  parameter  bit          WRAP       = 1'b1,
  parameter  int unsigned RPT_CYCLES = 25_000_000,
  localparam int unsigned DIGITS     = (N + 3) / 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_n,
  input  logic                inc_n,
  input  logic                load_n,
  input  logic [N-1:0]        init_value,
  output logic [N-1:0]        count,
  output logic                zero,
  output logic                max,
  output logic [7*DIGITS-1:0] segments
);
  import contador_pkg::*;

  localparam logic [N-1:0] CNT_MAX = '1;

  logic dec_p, inc_p, load_p;
  logic [4*DIGITS-1:0] count_ext;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .RPT_CYCLES(RPT_CYCLES), .REPEAT_EN(1'b1))
    u_dec (.clk(clk), .reset(reset), .key_n(dec_n), .press(dec_p));

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .RPT_CYCLES(RPT_CYCLES), .REPEAT_EN(1'b1))
    u_inc (.clk(clk), .reset(reset), .key_n(inc_n), .press(inc_p));

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .RPT_CYCLES(RPT_CYCLES), .REPEAT_EN(1'b0))
    u_load (.clk(clk), .reset(reset), .key_n(load_n), .press(load_p));

  // Load wins; simultaneous inc and dec cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load_p) begin
      count <= init_value;
    end else if (inc_p && !dec_p) begin
      if (count != CNT_MAX) count <= count + 1'b1;
      else if (WRAP)        count <= '0;
    end else if (dec_p && !inc_p) begin
      if (count != '0)      count <= count - 1'b1;
      else if (WRAP)        count <= CNT_MAX;
    end
  end

  assign zero = (count == '0);
  assign max  = (count == CNT_MAX);

  // Zero-extend so the top digit's unused bits read as 0.
  assign count_ext = (4*DIGITS)'(count);

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign segments[7*d +: 7] = hex_to_seg(count_ext[4*d +: 4]);
  end

endmodule
